branch_resolve_queue: RTL and testbench
=======================================

# branch_resolve_queue

Tracks in-flight branch predictions between fetch and execute. Each prediction the branch predictor makes at fetch is pushed into a small FIFO together with its fall-through and predicted-target addresses. When the branch resolves in execute, the head entry is popped and compared with the actual outcome. On a mismatch the block raises a one-cycle `flush` and a `redirect_pc` for the fetch PC mux, and squashes all younger queued predictions.

## Interface
- `DEPTH`, 4: queue entries; power of two, minimum 2.
- `PTR`, 2: log2(`DEPTH`).
- `AW`, 32: address width.

Ports (name, direction, width, meaning):
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `push`  in  1  fetch-stage branch accepted into IF/ID (predictor output valid AND `if_id_write`).
- `push_taken`  in  1  predicted direction.
- `push_fall`  in  AW  fall-through address (fetch address + 4).
- `push_target`  in  AW  predicted taken target.
- `resolve`  in  1  execute-stage branch resolved this cycle.
- `resolve_taken`  in  1  actual direction.
- `resolve_target`  in  AW  actual taken target.
- `flush`  out  1  one-cycle mispredict pulse, registered.
- `redirect_pc`  out  AW  correct next PC; valid while `flush`=1.
- `empty`  out  1  no entries queued.
- `full`  out  1  `DEPTH` entries queued.
- `overflow`  out  1  sticky: push while full without a same-cycle pop.
- `underflow`  out  1  sticky: resolve while empty.
- `branch_count`  out  32  resolved branches.
- `mispredict_count`  out  32  mispredicted branches.

## Operation
- Storage: `DEPTH` entries of {taken, fall, target}. Read pointer `rd` and write pointer `wr` are each `PTR` bits and wrap modulo `DEPTH`. An occupancy counter `cnt` is `PTR+1` bits, range 0..`DEPTH`. `empty` = (`cnt`==0); `full` = (`cnt`==`DEPTH`).
- A pop occurs when `resolve`=1 and `cnt`≠0.
- Mispredict is combinational on the head entry during a pop:
  - `resolve_taken`≠head.taken, OR
  - `resolve_taken`=1 AND `resolve_target`≠head.target.
- Redirect address: if `resolve_taken`=1, `resolve_target`; otherwise head.fall.
- Mispredict pop, at the next edge:
  - `flush`←1 and `redirect_pc`←redirect address.
  - `rd`←0, `wr`←0, `cnt`←0. Any same-cycle push is discarded, because it is a younger wrong-path instruction.
- Normal pop, push, or both: `flush`←0, `redirect_pc` holds its value. Push writes to `wr` and increments it; pop increments `rd`. `cnt` changes by +1, −1, or 0 when both occur.
- Push and pop in the same cycle while full: legal. The entry is written and `cnt` stays at `DEPTH`.
- Push while full without a pop: the entry is dropped, state is unchanged, and `overflow`←1.
- Resolve while empty: ignored and `underflow`←1. No flush, no count change.
- Sticky flags clear only on reset.
- Counters: `branch_count` +1 per pop; `mispredict_count` +1 per mispredict pop. Both wrap at 2^32.

## Timing
- Reset (asynchronous, `rst_n`=0): `flush`=0, `redirect_pc`=0, `cnt`=0, `rd`=`wr`=0, `empty`=1, `full`=0, `overflow`=0, `underflow`=0, both counters 0. Entry contents are don't-care.
- Reset asserted mid-operation clears everything immediately, including an in-progress `flush` pulse.
- Resolve→flush latency is 1 cycle. `flush` is high for exactly one cycle per mispredict.
- Back-to-back mispredicts cannot occur after a flush, since the queue is empty and the next resolve sets `underflow`.
- `empty`/`full` reflect registered state and update on the edge after the push or pop.
- No combinational path from inputs to outputs.

## Configuration
- `BRANCH_RESOLVE_STATS_EN` defined: `branch_count` and `mispredict_count` are implemented as described.
- Not defined: the counter registers are omitted and both outputs are tied to 0. All other behaviour is identical.

## Test plan
- Reset, then idle 5 cycles. Expect `empty`=1, `full`=0, `flush`=0, `redirect_pc`=0, counters 0.
- Push taken/fall=0x104/target=0x200, then resolve taken/target=0x200. Expect no flush, `empty`=1, `branch_count`=1, `mispredict_count`=0.
- Push not-taken/fall=0x108, then resolve taken/target=0x300. Expect one cycle later `flush`=1 for one cycle with `redirect_pc`=0x300, and `mispredict_count`=1.
- Push 3 entries; the first is taken/target=0x400. Resolve taken/target=0x480 while pushing a 4th entry in the same cycle. Expect `redirect_pc`=0x480 and `cnt`=0 afterwards (all 4 entries squashed).
- Push 5 entries with no resolve. Expect `full`=1 after the 4th and `overflow`=1 after the 5th. Then push and resolve in the same cycle: `full` stays 1 and the first entry is compared.
- Resolve with the queue empty. Expect `underflow`=1, no flush, counters unchanged.
- With `BRANCH_RESOLVE_STATS_EN` undefined, rerun the mispredict scenario. Expect both counters to read 0.

Source files
------------

// File: rtl/branch_resolve_queue.sv
// Branch resolve queue: FIFO of fetch-time predictions, checked against execute outcomes; flush/redirect on mispredict.
// Latency: resolve -> flush/redirect_pc 1 cycle; empty/full/flags update on the edge after the push or pop.
// Backpressure: none; push while full (no pop) is dropped and sets overflow. BRANCH_RESOLVE_STATS_EN enables counters.
module branch_resolve_queue #(
  parameter int DEPTH = 4,
  parameter int PTR   = 2,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          push_taken,
  input  logic [AW-1:0] push_fall,
  input  logic [AW-1:0] push_target,
  input  logic          resolve,
  input  logic          resolve_taken,
  input  logic [AW-1:0] resolve_target,
  output logic          flush,
  output logic [AW-1:0] redirect_pc,
  output logic          empty,
  output logic          full,
  output logic          overflow,
  output logic          underflow,
  output logic [31:0]   branch_count,
  output logic [31:0]   mispredict_count
);

  localparam logic [PTR:0] FULL_CNT = (PTR+1)'(DEPTH);

  logic [DEPTH-1:0] taken_q;
  logic [AW-1:0]    fall_q   [DEPTH];
  logic [AW-1:0]    target_q [DEPTH];

  logic [PTR-1:0] rd_q, rd_d;
  logic [PTR-1:0] wr_q, wr_d;
  logic [PTR:0]   cnt_q, cnt_d;
  logic           flush_q, flush_d;
  logic [AW-1:0]  redirect_q, redirect_d;
  logic           overflow_q, overflow_d;
  logic           underflow_q, underflow_d;

  logic          is_empty;
  logic          is_full;
  logic          pop;
  logic          head_taken;
  logic [AW-1:0] head_fall;
  logic [AW-1:0] head_target;
  logic          mispredict;
  logic [AW-1:0] redirect_addr;
  logic          wr_en;

  always_comb begin
    is_empty      = (cnt_q == '0);
    is_full       = (cnt_q == FULL_CNT);
    pop           = resolve && !is_empty;
    head_taken    = taken_q[rd_q];
    head_fall     = fall_q[rd_q];
    head_target   = target_q[rd_q];
    mispredict    = pop && ((resolve_taken != head_taken) ||
                            (resolve_taken && (resolve_target != head_target)));
    redirect_addr = resolve_taken ? resolve_target : head_fall;
    // A push alongside a mispredict is wrong-path and must not enter the queue.
    wr_en         = push && !mispredict && (!is_full || pop);
  end

  always_comb begin
    rd_d        = rd_q;
    wr_d        = wr_q;
    cnt_d       = cnt_q;
    flush_d     = 1'b0;
    redirect_d  = redirect_q;
    overflow_d  = overflow_q | (push && is_full && !pop);
    underflow_d = underflow_q | (resolve && is_empty);
    if (mispredict) begin
      rd_d       = '0;
      wr_d       = '0;
      cnt_d      = '0;
      flush_d    = 1'b1;
      redirect_d = redirect_addr;
    end else begin
      if (wr_en) wr_d = wr_q + 1'b1;
      if (pop)   rd_d = rd_q + 1'b1;
      case ({wr_en, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q        <= '0;
      wr_q        <= '0;
      cnt_q       <= '0;
      flush_q     <= 1'b0;
      redirect_q  <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      cnt_q       <= cnt_d;
      flush_q     <= flush_d;
      redirect_q  <= redirect_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Entry payload needs no reset: it is only read when cnt says it is valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      taken_q[wr_q]  <= push_taken;
      fall_q[wr_q]   <= push_fall;
      target_q[wr_q] <= push_target;
    end
  end

`ifdef BRANCH_RESOLVE_STATS_EN
  logic [31:0] branch_count_q;
  logic [31:0] mispredict_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      if (pop)        branch_count_q     <= branch_count_q + 32'd1;
      if (mispredict) mispredict_count_q <= mispredict_count_q + 32'd1;
    end
  end

  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;
`else
  assign branch_count     = '0;
  assign mispredict_count = '0;
`endif

  assign flush       = flush_q;
  assign redirect_pc = redirect_q;
  assign empty       = is_empty;
  assign full        = is_full;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Bench for branch_resolve_queue: directed vector table, mid-flush reset, then random traffic against a queue model.
module tb_branch_resolve_queue;

`ifdef BRANCH_RESOLVE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        push, push_taken, resolve, resolve_taken;
  logic [31:0] push_fall, push_target, resolve_target;
  logic        flush, empty, full, overflow, underflow;
  logic [31:0] redirect_pc, branch_count, mispredict_count;

  int n_checks = 0;
  int n_fail   = 0;

  branch_resolve_queue #(.DEPTH(DEPTH), .PTR(2), .AW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .push(push), .push_taken(push_taken), .push_fall(push_fall), .push_target(push_target),
    .resolve(resolve), .resolve_taken(resolve_taken), .resolve_target(resolve_target),
    .flush(flush), .redirect_pc(redirect_pc), .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        p, pt;
    logic [31:0] pf, ptg;
    logic        r, rt;
    logic [31:0] rtg;
    logic        e_flush;
    logic [31:0] e_redir;
    logic        e_empty, e_full, e_ovf, e_unf;
    logic [31:0] e_bc, e_mc;
  } vec_t;

  typedef struct {
    bit          t;
    logic [31:0] f, g;
  } ent_t;

  vec_t vt[23];
  ent_t mq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic ef, input logic [31:0] er,
                           input logic ee, input logic efu, input logic eo, input logic eu,
                           input logic [31:0] ebc, input logic [31:0] emc);
    check({tag, ".flush"}, 32'(flush), 32'(ef));
    check({tag, ".redirect_pc"}, redirect_pc, er);
    check({tag, ".empty"}, 32'(empty), 32'(ee));
    check({tag, ".full"}, 32'(full), 32'(efu));
    check({tag, ".overflow"}, 32'(overflow), 32'(eo));
    check({tag, ".underflow"}, 32'(underflow), 32'(eu));
    check({tag, ".branch_count"}, branch_count, STATS ? ebc : 32'd0);
    check({tag, ".mispredict_count"}, mispredict_count, STATS ? emc : 32'd0);
  endtask

  task automatic drive(input logic p, input logic pt, input logic [31:0] pf, input logic [31:0] ptg,
                       input logic r, input logic rt, input logic [31:0] rtg);
    push = p; push_taken = pt; push_fall = pf; push_target = ptg;
    resolve = r; resolve_taken = rt; resolve_target = rtg;
  endtask

  function automatic vec_t mk(input logic p, input logic pt, input logic [31:0] pf, input logic [31:0] ptg,
                              input logic r, input logic rt, input logic [31:0] rtg,
                              input logic ef, input logic [31:0] er, input logic ee, input logic efu,
                              input logic eo, input logic eu, input logic [31:0] ebc, input logic [31:0] emc);
    vec_t v;
    v.p = p; v.pt = pt; v.pf = pf; v.ptg = ptg; v.r = r; v.rt = rt; v.rtg = rtg;
    v.e_flush = ef; v.e_redir = er; v.e_empty = ee; v.e_full = efu;
    v.e_ovf = eo; v.e_unf = eu; v.e_bc = ebc; v.e_mc = emc;
    return v;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //        push pt fall      target    res rt rtarget   | flush redir     emp full ovf unf bc mc
    vt[0]  = mk(0, 0, 0,        0,        0, 0, 0,          0, 0,        1, 0, 0, 0, 0, 0);
    vt[1]  = mk(1, 1, 32'h104,  32'h200,  0, 0, 0,          0, 0,        0, 0, 0, 0, 0, 0);
    vt[2]  = mk(0, 0, 0,        0,        1, 1, 32'h200,    0, 0,        1, 0, 0, 0, 1, 0);
    vt[3]  = mk(1, 0, 32'h108,  32'h10c,  0, 0, 0,          0, 0,        0, 0, 0, 0, 1, 0);
    vt[4]  = mk(0, 0, 0,        0,        1, 1, 32'h300,    1, 32'h300,  1, 0, 0, 0, 2, 1);
    vt[5]  = mk(0, 0, 0,        0,        0, 0, 0,          0, 32'h300,  1, 0, 0, 0, 2, 1);
    vt[6]  = mk(1, 1, 32'h110,  32'h400,  0, 0, 0,          0, 32'h300,  0, 0, 0, 0, 2, 1);
    vt[7]  = mk(1, 0, 32'h114,  32'h500,  0, 0, 0,          0, 32'h300,  0, 0, 0, 0, 2, 1);
    vt[8]  = mk(1, 1, 32'h118,  32'h600,  0, 0, 0,          0, 32'h300,  0, 0, 0, 0, 2, 1);
    vt[9]  = mk(1, 0, 32'h11c,  32'h700,  1, 1, 32'h480,    1, 32'h480,  1, 0, 0, 0, 3, 2);
    vt[10] = mk(0, 0, 0,        0,        0, 0, 0,          0, 32'h480,  1, 0, 0, 0, 3, 2);
    vt[11] = mk(1, 1, 32'h120,  32'h800,  0, 0, 0,          0, 32'h480,  0, 0, 0, 0, 3, 2);
    vt[12] = mk(1, 0, 32'h124,  32'h900,  0, 0, 0,          0, 32'h480,  0, 0, 0, 0, 3, 2);
    vt[13] = mk(1, 1, 32'h128,  32'ha00,  0, 0, 0,          0, 32'h480,  0, 0, 0, 0, 3, 2);
    vt[14] = mk(1, 0, 32'h12c,  32'hb00,  0, 0, 0,          0, 32'h480,  0, 1, 0, 0, 3, 2);
    vt[15] = mk(1, 1, 32'h130,  32'hc00,  0, 0, 0,          0, 32'h480,  0, 1, 1, 0, 3, 2);
    vt[16] = mk(1, 0, 32'h134,  32'hd00,  1, 1, 32'h800,    0, 32'h480,  0, 1, 1, 0, 4, 2);
    vt[17] = mk(0, 0, 0,        0,        1, 0, 32'hfff,    0, 32'h480,  0, 0, 1, 0, 5, 2);
    vt[18] = mk(0, 0, 0,        0,        1, 1, 32'ha00,    0, 32'h480,  0, 0, 1, 0, 6, 2);
    vt[19] = mk(0, 0, 0,        0,        1, 0, 32'h0,      0, 32'h480,  0, 0, 1, 0, 7, 2);
    vt[20] = mk(0, 0, 0,        0,        1, 0, 32'h0,      0, 32'h480,  1, 0, 1, 0, 8, 2);
    vt[21] = mk(0, 0, 0,        0,        1, 1, 32'h123,    0, 32'h480,  1, 0, 1, 1, 8, 2);
    vt[22] = mk(0, 0, 0,        0,        0, 0, 0,          0, 32'h480,  1, 0, 1, 1, 8, 2);

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    check_all("reset", 0, 0, 1, 0, 0, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_all($sformatf("idle%0d", i), 0, 0, 1, 0, 0, 0, 0, 0);
    end

    for (int i = 0; i < 23; i++) begin
      drive(vt[i].p, vt[i].pt, vt[i].pf, vt[i].ptg, vt[i].r, vt[i].rt, vt[i].rtg);
      @(posedge clk); #1;
      check_all($sformatf("vec%0d", i), vt[i].e_flush, vt[i].e_redir, vt[i].e_empty, vt[i].e_full,
                vt[i].e_ovf, vt[i].e_unf, vt[i].e_bc, vt[i].e_mc);
    end

    // Reset asserted while flush is high must clear it immediately.
    drive(1, 0, 32'h140, 32'h150, 0, 0, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 1, 1, 32'h300);
    @(posedge clk); #1;
    check_all("preflush", 1, 32'h300, 1, 0, 1, 1, 9, 3);
    drive(0, 0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1 check_all("midreset", 0, 0, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_all("postreset", 0, 0, 1, 0, 0, 0, 0, 0);

    // Random traffic against a queue-level model of the specified behaviour.
    begin
      bit          m_flush = 0, m_ovf = 0, m_unf = 0;
      logic [31:0] m_redir = 0, m_bc = 0, m_mc = 0;
      do_reset();
      mq.delete();
      for (int i = 0; i < 600; i++) begin
        bit p, pt, r, rt, mis;
        logic [31:0] pf, ptg, rtg;
        ent_t e, h;
        p   = ($urandom_range(0, 9) < 6);
        r   = ($urandom_range(0, 9) < (((i / 50) % 2 == 0) ? 2 : 5));
        pt  = 1'($urandom_range(0, 1));
        pf  = 32'h1000 + 32'(4 * i);
        ptg = 32'h100 * 32'($urandom_range(1, 3));
        rt  = 1'($urandom_range(0, 1));
        rtg = 32'h100 * 32'($urandom_range(1, 3));
        drive(p, pt, pf, ptg, r, rt, rtg);
        e.t = pt; e.f = pf; e.g = ptg;
        m_flush = 0;
        if (r && mq.size() == 0) begin
          m_unf = 1;
          if (p) mq.push_back(e);
        end else if (r) begin
          h = mq[0];
          mis = (rt != h.t) || (rt && rtg != h.g);
          m_bc++;
          if (mis) begin
            m_mc++;
            m_flush = 1;
            m_redir = rt ? rtg : h.f;
            mq.delete();
          end else begin
            void'(mq.pop_front());
            if (p) mq.push_back(e);
          end
        end else if (p) begin
          if (mq.size() == DEPTH) m_ovf = 1;
          else mq.push_back(e);
        end
        @(posedge clk); #1;
        check_all($sformatf("rnd%0d", i), m_flush, m_redir, mq.size() == 0, mq.size() == DEPTH,
                  m_ovf, m_unf, m_bc, m_mc);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
